uart_echo_beacon: RTL and testbench

UART_ECHO_BEACON -- requirements
Module: uart_echo_beacon

---
 rtl/uart_echo_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_echo_beacon.sv | 161 ++++++++++++++++
 tb/tb_uart_echo_beacon.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg
// Shared types and constants for uart_echo_beacon.
//   rd_state_t : read-side FSM states (FIFO -> transmitter)
//   b_state_t  : beacon FSM states (message ROM -> FIFO)
//   MSG_LEN    : beacon message length in bytes
//   MSG        : beacon message bytes, "Hello ALINX\r\n"
package uart_echo_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_SEND  = 2'd2
    } rd_state_t;

    typedef enum logic {
        B_WAIT = 1'b0,
        B_SEND = 1'b1
    } b_state_t;

    localparam int MSG_LEN = 13;

    localparam logic [7:0] MSG [MSG_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h41,
        8'h4C, 8'h49, 8'h4E, 8'h58, 8'h0D, 8'h0A
    };

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a registered read port.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers,
//                level and q; stored words are thereby discarded)
//   wrreq,data : write request and word; ignored while full, even when a
//                read happens in the same cycle
//   rdreq, q   : read request; q holds the popped word from the next cycle
//   empty,full : occupancy flags
//   level      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wrreq,
    input  logic [WIDTH-1:0]           data,
    input  logic                       rdreq,
    output logic [WIDTH-1:0]           q,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (level == '0);
    assign full  = (level == DEPTH_L);
    // Full is judged on the pre-read level, so a same-cycle read never
    // opens room for a write.
    assign do_wr = wrreq && !full;
    assign do_rd = rdreq && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            q      <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
                q      <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_beacon.sv
// uart_echo_beacon
// Buffers received UART bytes in a FIFO and offers them back to the
// transmitter; optionally injects a periodic "Hello ALINX\r\n" beacon.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_data     : received byte, qualified by rx_data_en (1-cycle strobe)
//   beacon_en   : level enabling the periodic beacon
//   tx_data     : byte offered to the transmitter
//   tx_data_en  : high while tx_data is offered; valid/ready handshake:
//                 the byte is consumed on the cycle tx_done pulses while
//                 tx_data_en is high; tx_data is stable until then
//   tx_done     : 1-cycle consume pulse, ignored unless a byte is offered
//   fifo_level  : FIFO occupancy
//   drop_cnt    : saturating count of rx bytes lost to a full FIFO
//   overflow    : sticky, set on the first drop, cleared only by reset
// Build option: define UART_ECHO_BEACON_EN to include the beacon FSM, timer
// and message ROM; without it the block is a pure buffered echo.
module uart_echo_beacon
    import uart_echo_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int BEACON_PERIOD = 50_000_000,
    parameter int DROP_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_data_en,
    input  logic                          beacon_en,
    output logic [7:0]                    tx_data,
    output logic                          tx_data_en,
    input  logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_cnt,
    output logic                          overflow
);

    logic       fifo_wr;
    logic [7:0] fifo_din;
    logic       fifo_rd;
    logic [7:0] fifo_q;
    logic       fifo_empty;
    logic       fifo_full;
    rd_state_t  rd_state;

`ifdef UART_ECHO_BEACON_EN
    localparam int TW = $clog2(BEACON_PERIOD);

    b_state_t   b_state;
    logic [TW-1:0] timer;
    logic [3:0] idx;
    logic       beacon_wr;

    // rx owns the write port; a beacon byte simply waits (idx holds).
    assign beacon_wr = (b_state == B_SEND) && !rx_data_en && !fifo_full;
    assign fifo_wr   = rx_data_en || beacon_wr;
    assign fifo_din  = rx_data_en ? rx_data : MSG[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state <= B_WAIT;
            timer   <= '0;
            idx     <= '0;
        end else begin
            case (b_state)
                B_WAIT: begin
                    if (!beacon_en) begin
                        timer <= '0;
                    end else if (timer == TW'(BEACON_PERIOD - 1)) begin
                        timer   <= '0;
                        idx     <= '0;
                        b_state <= B_SEND;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                B_SEND: begin
                    // beacon_en is not looked at here: a started message
                    // always completes, and the timer stays frozen.
                    if (beacon_wr) begin
                        if (idx == 4'(MSG_LEN - 1)) begin
                            idx     <= '0;
                            timer   <= '0;
                            b_state <= B_WAIT;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: b_state <= B_WAIT;
            endcase
        end
    end
`else
    localparam int unused_period = BEACON_PERIOD;
    logic unused_beacon_en;

    assign unused_beacon_en = beacon_en;
    assign fifo_wr          = rx_data_en;
    assign fifo_din         = rx_data;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wrreq (fifo_wr),
        .data  (fifo_din),
        .rdreq (fifo_rd),
        .q     (fifo_q),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Pop from IDLE so that q is ready while in FETCH.
    assign fifo_rd = (rd_state == RD_IDLE) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state   <= RD_IDLE;
            tx_data    <= '0;
            tx_data_en <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (!fifo_empty) begin
                        rd_state <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    tx_data    <= fifo_q;
                    tx_data_en <= 1'b1;
                    rd_state   <= RD_SEND;
                end
                RD_SEND: begin
                    if (tx_done) begin
                        tx_data_en <= 1'b0;
                        rd_state   <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // A byte is dropped only when rx arrives with the FIFO full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (rx_data_en && fifo_full) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_beacon.sv
// tb_uart_echo_beacon
// Directed bench for uart_echo_beacon (FIFO_DEPTH=4, BEACON_PERIOD=100,
// DROP_W=2). Inputs change on the falling edge, outputs are sampled on the
// falling edge. Beacon scenarios are built when UART_ECHO_BEACON_EN is
// defined; otherwise the bench confirms beacon_en has no effect.
module tb_uart_echo_beacon;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_en;
    logic       beacon_en;
    logic       man_done;
    logic       auto_done = 1'b0;
    wire        tx_done = man_done | auto_done;
    logic [7:0] tx_data;
    logic       tx_data_en;
    logic [2:0] fifo_level;
    logic [1:0] drop_cnt;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    bit tx_auto = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] msg_b [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h41,
                               8'h4C, 8'h49, 8'h4E, 8'h58, 8'h0D, 8'h0A};

    always #5 clk = ~clk;

    uart_echo_beacon #(
        .FIFO_DEPTH    (4),
        .BEACON_PERIOD (100),
        .DROP_W        (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_data_en (rx_data_en),
        .beacon_en  (beacon_en),
        .tx_data    (tx_data),
        .tx_data_en (tx_data_en),
        .tx_done    (tx_done),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    // Transmitter model: records each offered byte, consumes it 2 cycles later.
    always begin
        @(negedge clk);
        if (tx_auto && tx_data_en) begin
            got_q.push_back(tx_data);
            @(negedge clk);
            auto_done = 1'b1;
            @(negedge clk);
            auto_done = 1'b0;
        end
    end

`ifdef UART_ECHO_BEACON_EN
    int cyc = 0;
    int wr_cyc[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) if (dut.beacon_wr) wr_cyc.push_back(cyc);
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data    = b;
        rx_data_en = 1'b1;
        @(negedge clk);
        rx_data_en = 1'b0;
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, got_q.size(), n);
    endtask

    task automatic check_stream(input string tag);
        int i = 0;
        logic [7:0] e;
        logic [31:0] g;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? {24'h0, got_q.pop_front()} : 32'hFFFF_FFFF;
            check($sformatf("%s_%0d", tag, i), g, {24'h0, e});
            i++;
        end
        got_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst_n = 1'b0; rx_data = 8'h00; rx_data_en = 1'b0;
        beacon_en = 1'b0; man_done = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_en", tx_data_en, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_drop", drop_cnt, 2'd0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // echo latency: strobe in cycle N, offered in cycle N+3
        @(negedge clk);
        rx_data = 8'h41; rx_data_en = 1'b1;
        @(negedge clk);
        rx_data_en = 1'b0;
        check("echo_n1_en", tx_data_en, 1'b0);
        @(negedge clk);
        check("echo_n2_en", tx_data_en, 1'b0);
        @(negedge clk);
        check("echo_n3_en", tx_data_en, 1'b1);
        check("echo_n3_data", tx_data, 8'h41);
        pulse_done();
        check("echo_done_en", tx_data_en, 1'b0);
        check("echo_hold_data", tx_data, 8'h41);
        check("echo_level", fifo_level, 3'd0);

        // tx_done during FETCH must be ignored
        @(negedge clk);
        rx_data = 8'h42; rx_data_en = 1'b1;
        @(negedge clk);
        rx_data_en = 1'b0;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("ign_en", tx_data_en, 1'b1);
        check("ign_data", tx_data, 8'h42);
        @(negedge clk);
        check("ign_en_hold", tx_data_en, 1'b1);
        pulse_done();
        check("ign_release", tx_data_en, 1'b0);

        // same-cycle read and write keeps the level
        @(negedge clk);
        rx_data = 8'h51; rx_data_en = 1'b1;
        @(negedge clk);
        rx_data = 8'h52;
        @(negedge clk);
        rx_data_en = 1'b0;
        check("rw_level", fifo_level, 3'd1);
        tx_auto = 1'b1;
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h52);
        wait_got(2, 50, "rw_wait");
        check_stream("rw_order");
        repeat (6) @(negedge clk);
        tx_auto = 1'b0;
        check("rw_drained", fifo_level, 3'd0);

        // overflow: one byte held in the transmitter, then 6 rx bytes
        send_rx(8'h0F);
        repeat (2) @(negedge clk);
        check("ovf_busy", tx_data_en, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rx_data = 8'h10 + 8'(i); rx_data_en = 1'b1;
            @(negedge clk);
        end
        rx_data_en = 1'b0;
        check("ovf_level", fifo_level, 3'd4);
        check("ovf_drop", drop_cnt, 2'd2);
        check("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 2; i++) begin
            rx_data = 8'h20 + 8'(i); rx_data_en = 1'b1;
            @(negedge clk);
        end
        rx_data_en = 1'b0;
        check("ovf_drop_sat", drop_cnt, 2'd3);
        check("ovf_level_full", fifo_level, 3'd4);
        check("ovf_held_byte", tx_data, 8'h0F);
        // full blocks a write even on the cycle the FIFO is popped
        pulse_done();
        rx_data = 8'h77; rx_data_en = 1'b1;
        @(negedge clk);
        rx_data_en = 1'b0;
        check("full_rw_level", fifo_level, 3'd3);
        tx_auto = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        wait_got(4, 100, "ovf_wait");
        check_stream("ovf_order");
        repeat (6) @(negedge clk);
        tx_auto = 1'b0;
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_drained", fifo_level, 3'd0);

        // asynchronous reset while sending with 3 bytes queued
        send_rx(8'h31);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'h32 + 8'(i); rx_data_en = 1'b1;
            @(negedge clk);
        end
        rx_data_en = 1'b0;
        check("mid_level", fifo_level, 3'd3);
        check("mid_en", tx_data_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_en", tx_data_en, 1'b0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_level", fifo_level, 3'd0);
        check("arst_drop", drop_cnt, 2'd0);
        check("arst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_data_en) hi++;
        end
        check("arst_no_stale", hi, 0);

`ifdef UART_ECHO_BEACON_EN
        // beacon with an rx byte landing on index 3
        @(negedge clk);
        rst_n = 1'b0;
        beacon_en = 1'b1;
        tx_auto = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (103) @(posedge clk);
        @(negedge clk);
        rx_data = 8'h5A; rx_data_en = 1'b1;
        @(negedge clk);
        rx_data_en = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(msg_b[i]);
        exp_q.push_back(8'h5A);
        for (int i = 3; i < 13; i++) exp_q.push_back(msg_b[i]);
        wait_got(14, 400, "col_wait");
        check_stream("col_order");
        check("col_drop", drop_cnt, 2'd0);
        check("col_ovf", overflow, 1'b0);

        // second message: disable beacon_en once index 5 is reached
        begin
            int k = 0;
            while (wr_cyc.size() < 18 && k < 400) begin
                @(negedge clk);
                k++;
            end
            check("dis_reach_idx5", (wr_cyc.size() >= 18), 1'b1);
        end
        beacon_en = 1'b0;
        for (int i = 0; i < 13; i++) exp_q.push_back(msg_b[i]);
        wait_got(13, 300, "dis_wait");
        check_stream("dis_order");
        // 100 idle cycles between the last write and the next message
        check("beacon_gap", wr_cyc[13] - wr_cyc[12], 101);
        repeat (300) @(negedge clk);
        check("dis_writes", wr_cyc.size(), 26);
        check("dis_no_more_tx", got_q.size(), 0);
        tx_auto = 1'b0;
`else
        // without the beacon build, beacon_en does nothing
        @(negedge clk);
        rst_n = 1'b0;
        beacon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_data_en) hi++;
        end
        check("nobeacon_tx", hi, 0);
        check("nobeacon_level", fifo_level, 3'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
